// File: rtl/dut_alu.sv
// rtl/dut_alu.sv - registered 16-op ALU with REG/MEM/IMM operand-B select
// Optional CARRY/ZERO outputs are enabled by defining ALU_FLAGS_EN.
module dut_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ACT,
    input  logic [3:0]            OP,
    input  logic [1:0]            MOVI,
    input  logic [DATA_WIDTH-1:0] REG_A,
    input  logic [DATA_WIDTH-1:0] REG_B,
    input  logic [DATA_WIDTH-1:0] MEM,
    input  logic [DATA_WIDTH-1:0] IMM,
    output logic                  ALU_RDY,
    output logic [DATA_WIDTH-1:0] EX_ALU,
    output logic                  EX_ALU_VLD
`ifdef ALU_FLAGS_EN
    ,
    output logic                  CARRY,
    output logic                  ZERO
`endif
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH-1:0] add_r;
    logic [DATA_WIDTH-1:0] sub_r;
    logic [DATA_WIDTH-1:0] mul_r;
    logic [DATA_WIDTH-1:0] res;
    logic                  accept;
    logic                  pend_vld;
    logic [DATA_WIDTH-1:0] pend_res;

    assign accept = ACT && ALU_RDY;

    always_comb begin
        case (MOVI)
            2'b01:   opb = MEM;
            2'b10:   opb = IMM;
            default: opb = REG_B;
        endcase
    end

    assign add_r = REG_A + opb;
    assign sub_r = REG_A - opb;
    assign mul_r = REG_A * opb;

    always_comb begin
        case (OP)
            4'b0000: res = add_r;
            4'b0001: res = sub_r;
            4'b0010: res = mul_r;
            4'b0011: res = {REG_A[DATA_WIDTH-2:0], 1'b0};
            4'b0100: res = {1'b0, REG_A[DATA_WIDTH-1:1]};
            4'b0101: res = {REG_A[DATA_WIDTH-2:0], REG_A[DATA_WIDTH-1]};
            4'b0110: res = {REG_A[0], REG_A[DATA_WIDTH-1:1]};
            4'b0111: res = ~REG_A;
            4'b1000: res = REG_A & opb;
            4'b1001: res = REG_A | opb;
            4'b1010: res = REG_A ^ opb;
            4'b1011: res = ~(REG_A & opb);
            4'b1100: res = ~(REG_A | opb);
            4'b1101: res = ~(REG_A ^ opb);
            4'b1110: res = REG_A + ONE;
            default: res = REG_A - ONE;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [2*DATA_WIDTH-1:0] prod_w;
    logic                    carry_c;
    logic                    pend_carry;

    assign prod_w = {{DATA_WIDTH{1'b0}}, REG_A} * {{DATA_WIDTH{1'b0}}, opb};

    // Carry-out of ADD shows up as a wrapped sum smaller than an operand.
    always_comb begin
        case (OP)
            4'b0000:          carry_c = (add_r < REG_A);
            4'b0001:          carry_c = (REG_A < opb);
            4'b0010:          carry_c = (prod_w > {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}});
            4'b0011, 4'b0101: carry_c = REG_A[DATA_WIDTH-1];
            4'b0100, 4'b0110: carry_c = REG_A[0];
            4'b1110:          carry_c = &REG_A;
            4'b1111:          carry_c = ~|REG_A;
            default:          carry_c = 1'b0;
        endcase
    end
`endif

    // Stage 1 captures the accepted result; stage 2 presents it for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALU_RDY    <= 1'b0;
            pend_vld   <= 1'b0;
            pend_res   <= '0;
            EX_ALU     <= '0;
            EX_ALU_VLD <= 1'b0;
`ifdef ALU_FLAGS_EN
            pend_carry <= 1'b0;
            CARRY      <= 1'b0;
            ZERO       <= 1'b0;
`endif
        end else begin
            ALU_RDY    <= 1'b1;
            pend_vld   <= accept;
            EX_ALU_VLD <= pend_vld;
            if (accept) begin
                pend_res <= res;
`ifdef ALU_FLAGS_EN
                pend_carry <= carry_c;
`endif
            end
            if (pend_vld) begin
                EX_ALU <= pend_res;
`ifdef ALU_FLAGS_EN
                CARRY <= pend_carry;
                ZERO  <= (pend_res == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_dut_alu.sv
// tb/tb_dut_alu.sv - self-checking bench for dut_alu against an arithmetic reference model
module tb_dut_alu;

    logic       CLK;
    logic       RESET;
    logic       ACT;
    logic [3:0] OP;
    logic [1:0] MOVI;
    logic [7:0] REG_A;
    logic [7:0] REG_B;
    logic [7:0] MEM;
    logic [7:0] IMM;
    logic       ALU_RDY;
    logic [7:0] EX_ALU;
    logic       EX_ALU_VLD;
`ifdef ALU_FLAGS_EN
    logic       CARRY;
    logic       ZERO;
`endif

    int errors = 0;
    int checks = 0;

    bit rdy_model = 0;
    bit pend_v = 0;
    int pend_res = 0;
    int pend_c = 0;
    bit exp_vld = 0;
    int exp_out = 0;
    int exp_c = 0;
    int exp_z = 0;

    dut_alu #(.DATA_WIDTH(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ACT(ACT),
        .OP(OP),
        .MOVI(MOVI),
        .REG_A(REG_A),
        .REG_B(REG_B),
        .MEM(MEM),
        .IMM(IMM),
        .ALU_RDY(ALU_RDY),
        .EX_ALU(EX_ALU),
        .EX_ALU_VLD(EX_ALU_VLD)
`ifdef ALU_FLAGS_EN
        ,
        .CARRY(CARRY),
        .ZERO(ZERO)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int ref_res(input int op, input int a, input int b);
        int r;
        case (op)
            0:  r = a + b;
            1:  r = a - b + 256;
            2:  r = a * b;
            3:  r = a * 2;
            4:  r = a / 2;
            5:  r = a * 2 + a / 128;
            6:  r = a / 2 + (a % 2) * 128;
            7:  r = 255 - a;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = 255 - (a ^ b);
            14: r = a + 1;
            default: r = a + 255;
        endcase
        return r % 256;
    endfunction

    function automatic int ref_carry(input int op, input int a, input int b);
        case (op)
            0:    return (a + b > 255) ? 1 : 0;
            1:    return (a < b) ? 1 : 0;
            2:    return (a * b > 255) ? 1 : 0;
            3, 5: return (a >= 128) ? 1 : 0;
            4, 6: return a % 2;
            14:   return (a == 255) ? 1 : 0;
            15:   return (a == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict what the edge accepts and what it delivers, then compare.
    task automatic tick();
        int b;
        bit acc;
        bit rst;
        int e_res;
        int e_c;
        b = (MOVI == 2'b01) ? int'(MEM) : (MOVI == 2'b10) ? int'(IMM) : int'(REG_B);
        acc = ACT && rdy_model && !RESET;
        rst = RESET;
        e_res = ref_res(int'(OP), int'(REG_A), b);
        e_c = ref_carry(int'(OP), int'(REG_A), b);
        @(posedge CLK);
        #1;
        if (rst) begin
            exp_vld = 0; exp_out = 0; exp_c = 0; exp_z = 0;
        end else if (pend_v) begin
            exp_vld = 1; exp_out = pend_res; exp_c = pend_c; exp_z = (pend_res == 0) ? 1 : 0;
        end else begin
            exp_vld = 0;
        end
        pend_v = acc;
        pend_res = e_res;
        pend_c = e_c;
        rdy_model = !rst;
        check("alu_rdy", int'(ALU_RDY), int'(rdy_model));
        check("ex_alu_vld", int'(EX_ALU_VLD), int'(exp_vld));
        check("ex_alu", int'(EX_ALU), exp_out);
`ifdef ALU_FLAGS_EN
        check("carry", int'(CARRY), exp_c);
        check("zero", int'(ZERO), exp_z);
`endif
    endtask

    task automatic set_in(input int op, input int movi, input int a, input int rb, input int mem, input int imm);
        OP = 4'(op); MOVI = 2'(movi); REG_A = 8'(a); REG_B = 8'(rb); MEM = 8'(mem); IMM = 8'(imm);
    endtask

    // Single request, then scrambled inputs while the result is pending.
    task automatic do_op(input string tag, input int op, input int movi, input int a, input int rb,
                         input int mem, input int imm, input int want);
        set_in(op, movi, a, rb, mem, imm);
        ACT = 1'b1;
        tick();
        ACT = 1'b0;
        set_in(int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(255)),
               int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
        tick();
        check({tag, "_vld"}, int'(EX_ALU_VLD), 1);
        check(tag, int'(EX_ALU), want);
    endtask

    int log_res[16];
    int vld_cnt;

    initial begin
        RESET = 1'b1;
        ACT = 1'b1;
        set_in(0, 0, 8'h12, 8'h34, 8'h56, 8'h78);

        for (int i = 0; i < 3; i++) tick();
        check("reset_rdy", int'(ALU_RDY), 0);
        check("reset_vld", int'(EX_ALU_VLD), 0);
        check("reset_ex", int'(EX_ALU), 0);

        RESET = 1'b0;
        ACT = 1'b0;
        tick();
        check("rdy_after_release", int'(ALU_RDY), 1);

        do_op("add_f0_20", 0, 0, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h10);
`ifdef ALU_FLAGS_EN
        check("add_carry", int'(CARRY), 1);
`endif
        do_op("sub_mem", 1, 1, 8'h05, 8'h99, 8'h07, 8'h44, 8'hFE);
        do_op("sub_imm", 1, 2, 8'h05, 8'h99, 8'h07, 8'h03, 8'h02);
        do_op("sub_rsv", 1, 3, 8'h05, 8'h01, 8'h07, 8'h03, 8'h04);
        do_op("shl_81", 3, 0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h02);
        do_op("shr_81", 4, 0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h40);
        do_op("rol_81", 5, 0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h03);
        do_op("ror_81", 6, 0, 8'h81, 8'h00, 8'h00, 8'h00, 8'hC0);
        do_op("mult_10_11", 2, 0, 8'h10, 8'h11, 8'h00, 8'h00, 8'h10);

        vld_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                set_in(i, 0, 8'hAA, 8'h0F, 8'h00, 8'h00);
                ACT = 1'b1;
            end else begin
                ACT = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 16) begin
                log_res[i-1] = int'(EX_ALU);
                if (EX_ALU_VLD === 1'b1) vld_cnt++;
            end
        end
        check("b2b_vld_count", vld_cnt, 16);
        check("b2b_add", log_res[0], 8'hB9);
        check("b2b_not", log_res[7], 8'h55);
        check("b2b_and", log_res[8], 8'h0A);
        check("b2b_or", log_res[9], 8'hAF);
        check("b2b_xor", log_res[10], 8'hA5);
        check("b2b_nand", log_res[11], 8'hF5);
        check("b2b_nor", log_res[12], 8'h50);
        check("b2b_xnor", log_res[13], 8'h5A);

        set_in(14, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        ACT = 1'b1;
        tick();
        RESET = 1'b1;
        ACT = 1'b0;
        tick();
        check("midreset_no_vld", int'(EX_ALU_VLD), 0);
        RESET = 1'b0;
        tick();
        check("midreset_still_no_vld", int'(EX_ALU_VLD), 0);
        do_op("inc_ff", 14, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        do_op("dec_00", 15, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);

        for (int i = 0; i < 400; i++) begin
            ACT = ($urandom_range(3) != 0);
            RESET = ($urandom_range(24) == 0);
            set_in(int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(255)),
                   int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
            tick();
        end
        RESET = 1'b0;
        ACT = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
